// File: rtl/codec_config_seq_if.sv
// Handshake bundle between the codec config sequencer and the I2C writer / host.
// master = sequencer side, slave = writer/host side.
interface codec_config_seq_if;
  logic        start;
  logic        finished;
  logic        enable;
  logic [15:0] data;
  logic [3:0]  index;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, finished,
    output enable, data, index, busy, done, error
  );

  modport slave (
    output start, finished,
    input  enable, data, index, busy, done, error
  );
endinterface

// File: rtl/codec_config_seq.sv
// Walks the WM8731 register table into the I2C writer, one word per ENABLE window with a settle gap.
// Outputs registered; a word is held until the writer's FINISHED edge or the watchdog fires.
module codec_config_seq #(
  parameter int NUM_REGS       = 11,
  parameter int GAP_CYCLES     = 2048,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic                 i_mclk,
  input logic                 i_reset,
  codec_config_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GAP, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [16:0] GAP_LAST = 17'(GAP_CYCLES - 1);
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);

  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0017;
      4'd2:    table_word = 16'h0217;
      4'd3:    table_word = 16'h0479;
      4'd4:    table_word = 16'h0679;
      4'd5:    table_word = 16'h0812;
      4'd6:    table_word = 16'h0A00;
      4'd7:    table_word = 16'h0C00;
      4'd8:    table_word = 16'h0E42;
      4'd9:    table_word = 16'h1001;
      4'd10:   table_word = 16'h1201;
      default: table_word = 16'h0000;
    endcase
  endfunction

  state_t      r_state;
  logic [16:0] r_timer;
  logic        r_start_q;
  logic        r_fin_q;
  logic        r_enable;
  logic [15:0] r_data;
  logic [3:0]  r_index;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic       w_start_rise;
  logic       w_fin_rise;
  logic [3:0] w_next_idx;

  assign w_start_rise = bus.start & ~r_start_q;
  assign w_fin_rise   = bus.finished & ~r_fin_q;
  assign w_next_idx   = r_index + 4'd1;

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_start_q <= 1'b0;
      r_fin_q   <= 1'b0;
      r_enable  <= 1'b0;
      r_data    <= '0;
      r_index   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_fin_q   <= bus.finished;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start_rise) begin
            r_index <= '0;
            r_data  <= table_word(4'd0);
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_timer <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // The watchdog counts only cycles the writer has actually seen ENABLE high.
          if (w_fin_rise) begin
            r_enable <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_GAP;
          end else if (r_enable && r_timer == TMO_LAST) begin
            r_enable <= 1'b0;
            r_error  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_ERR;
          end else begin
            r_enable <= 1'b1;
            if (r_enable) r_timer <= r_timer + 17'd1;
          end
        end
        S_GAP: begin
          if (r_timer == GAP_LAST) r_state <= S_NEXT;
          else                     r_timer <= r_timer + 17'd1;
        end
        S_NEXT: begin
          if (r_index == LAST_IDX) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_index <= w_next_idx;
            r_data  <= table_word(w_next_idx);
            r_timer <= '0;
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.enable = r_enable;
  assign bus.data   = r_data;
  assign bus.index  = r_index;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.error  = r_error;

endmodule

// File: tb/tb_codec_config_seq.sv
// Directed bench: full run, watchdog, START filtering, async reset and a one-word table.
// Limits are shrunk so every scenario fits in a few thousand cycles.
module tb_codec_config_seq;
  localparam int GAP   = 16;
  localparam int TMO   = 256;
  localparam int FDLY  = 40;
  localparam int FWID  = 8;
  localparam logic [15:0] EXP [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
                                         16'h0679, 16'h0812, 16'h0A00, 16'h0C00,
                                         16'h0E42, 16'h1001, 16'h1201};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  codec_config_seq_if bus ();
  codec_config_seq_if bus1 ();

  codec_config_seq #(.NUM_REGS(11), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .i_mclk(clk), .i_reset(rst), .bus(bus)
  );
  codec_config_seq #(.NUM_REGS(1), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut1 (
    .i_mclk(clk), .i_reset(rst), .bus(bus1)
  );

  int checks = 0;
  int passes = 0;

  // Writer model: FINISHED pulse FWID cycles long, FDLY cycles after ENABLE rises.
  logic fin_en;
  int   wstate = 0;
  int   wcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      wstate = 0;
      bus.finished = 1'b0;
    end else if (wstate == 0) begin
      bus.finished = 1'b0;
      if (bus.enable && fin_en) begin
        wstate = 1;
        wcnt = 0;
      end
    end else begin
      wcnt++;
      bus.finished = (wcnt > FDLY) && (wcnt <= FDLY + FWID);
      if (wcnt > FDLY + FWID && !bus.enable) wstate = 0;
    end
  end

  // Transfer monitor: logs each word at ENABLE rise and tallies protocol violations.
  logic [15:0] words [$];
  int          bad_pre = 0, bad_stable = 0, short_gap = 0, gap_cnt = 0;
  logic        prev_en = 1'b0;
  logic [15:0] prev_dat = '0;
  always @(negedge clk) begin
    if (bus.enable && !prev_en) begin
      words.push_back(bus.data);
      if (bus.data !== prev_dat) bad_pre++;
      if (bus.index != 4'd0 && gap_cnt < GAP) short_gap++;
    end
    if (bus.enable && prev_en && bus.data !== prev_dat) bad_stable++;
    gap_cnt  = bus.enable ? 0 : gap_cnt + 1;
    prev_en  = bus.enable;
    prev_dat = bus.data;
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.enable !== 1'b0) $display("FAIL reset_enable got %b want 0", bus.enable); else passes++;
    checks++; if (bus.data !== 16'h0000) $display("FAIL reset_data got %h want 0000", bus.data); else passes++;
    checks++; if (bus.index !== 4'd0) $display("FAIL reset_index got %0d want 0", bus.index); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passes++;
    checks++; if (bus.error !== 1'b0) $display("FAIL reset_error got %b want 0", bus.error); else passes++;
    checks++; if (bus1.done !== 1'b0 || bus1.enable !== 1'b0) $display("FAIL reset_dut1 got done=%b en=%b want 0 0", bus1.done, bus1.enable); else passes++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_run();
    int base, b_pre, b_st, b_gap, n;
    base = words.size(); b_pre = bad_pre; b_st = bad_stable; b_gap = short_gap;
    fin_en = 1'b1;
    pulse_start();
    checks++; if (bus.busy !== 1'b1 || bus.data !== 16'h1E00 || bus.enable !== 1'b0)
      $display("FAIL start_cycle got busy=%b data=%h en=%b want 1 1e00 0", bus.busy, bus.data, bus.enable); else passes++;
    n = 0;
    while (!bus.done && n < 3000) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1) $display("FAIL run_done_timeout got done=%b want 1", bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0 || bus.index !== 4'd10 || bus.enable !== 1'b0)
      $display("FAIL run_end got busy=%b idx=%0d en=%b want 0 10 0", bus.busy, bus.index, bus.enable); else passes++;
    checks++; if (words.size() - base != 11) $display("FAIL run_count got %0d want 11", words.size() - base); else passes++;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (base + i >= words.size() || words[base+i] !== EXP[i])
        $display("FAIL run_word%0d got %h want %h", i, (base + i < words.size()) ? words[base+i] : 16'hxxxx, EXP[i]);
      else passes++;
    end
    checks++; if (bad_pre != b_pre) $display("FAIL data_pre_valid got %0d violations want 0", bad_pre - b_pre); else passes++;
    checks++; if (bad_stable != b_st) $display("FAIL data_stable got %0d violations want 0", bad_stable - b_st); else passes++;
    checks++; if (short_gap != b_gap) $display("FAIL gap_len got %0d short gaps want 0", short_gap - b_gap); else passes++;
    repeat (50) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || words.size() - base != 11)
      $display("FAIL done_sticky got done=%b words=%0d want 1 11", bus.done, words.size() - base); else passes++;
  endtask

  task automatic test_timeout();
    int base, n;
    fin_en = 1'b0;
    pulse_start();
    n = 0;
    while (!bus.enable && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.enable !== 1'b1) $display("FAIL tmo_enable_rise got %b want 1", bus.enable); else passes++;
    n = 0;
    while (!bus.error && n < 400) begin @(negedge clk); n++; end
    checks++; if (n != TMO || bus.error !== 1'b1) $display("FAIL tmo_latency got %0d cycles err=%b want %0d 1", n, bus.error, TMO); else passes++;
    checks++; if (bus.enable !== 1'b0 || bus.index !== 4'd0 || bus.busy !== 1'b0)
      $display("FAIL tmo_state got en=%b idx=%0d busy=%b want 0 0 0", bus.enable, bus.index, bus.busy); else passes++;
    repeat (10) @(negedge clk);
    checks++; if (bus.error !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.error); else passes++;
    fin_en = 1'b1;
    base = words.size();
    pulse_start();
    checks++; if (bus.error !== 1'b0 || bus.busy !== 1'b1 || bus.index !== 4'd0 || bus.data !== 16'h1E00)
      $display("FAIL err_restart got err=%b busy=%b idx=%0d data=%h want 0 1 0 1e00", bus.error, bus.busy, bus.index, bus.data); else passes++;
    n = 0;
    while (!bus.done && n < 3000) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1 || words.size() - base != 11 || words[base] !== 16'h1E00)
      $display("FAIL err_rerun got done=%b words=%0d want 1 11", bus.done, words.size() - base); else passes++;
  endtask

  task automatic test_start_filter();
    int base, n, errs;
    base = words.size();
    bus.start = 1'b1;
    n = 0;
    while (!(bus.index == 4'd4 && bus.enable) && n < 3000) begin @(negedge clk); n++; end
    checks++; if (bus.index !== 4'd4) $display("FAIL reach_word4 got idx=%0d want 4", bus.index); else passes++;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 3000) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    errs = 0;
    for (int i = 0; i < 11; i++)
      if (base + i >= words.size() || words[base+i] !== EXP[i]) errs++;
    checks++; if (words.size() - base != 11 || errs != 0 || bus.done !== 1'b1 || bus.index !== 4'd10)
      $display("FAIL busy_start_ignored got words=%0d bad=%0d done=%b idx=%0d want 11 0 1 10", words.size() - base, errs, bus.done, bus.index); else passes++;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.index !== 4'd0 || bus.data !== 16'h1E00)
      $display("FAIL done_restart got done=%b busy=%b idx=%0d data=%h want 0 1 0 1e00", bus.done, bus.busy, bus.index, bus.data); else passes++;
  endtask

  task automatic test_async_reset();
    int base, n;
    n = 0;
    while (!(bus.index == 4'd5 && bus.enable) && n < 3000) begin @(negedge clk); n++; end
    checks++; if (bus.index !== 4'd5 || bus.enable !== 1'b1) $display("FAIL reach_word5 got idx=%0d en=%b want 5 1", bus.index, bus.enable); else passes++;
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.enable !== 1'b0 || bus.busy !== 1'b0 || bus.data !== 16'h0000)
      $display("FAIL async_reset got en=%b busy=%b data=%h want 0 0 0000", bus.enable, bus.busy, bus.data); else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = words.size();
    repeat (200) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.enable !== 1'b0 || bus.done !== 1'b0 || bus.index !== 4'd0 || words.size() != base)
      $display("FAIL post_reset_idle got busy=%b en=%b done=%b idx=%0d rises=%0d want 0 0 0 0 0", bus.busy, bus.enable, bus.done, bus.index, words.size() - base); else passes++;
  endtask

  task automatic test_single_word();
    int n;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 0;
    while (!bus1.enable && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus1.enable !== 1'b1 || bus1.data !== 16'h1E00)
      $display("FAIL single_word got en=%b data=%h want 1 1e00", bus1.enable, bus1.data); else passes++;
    repeat (FDLY) @(negedge clk);
    bus1.finished = 1'b1;
    repeat (FWID) @(negedge clk);
    bus1.finished = 1'b0;
    n = 0;
    while (!bus1.done && n < 200) begin @(negedge clk); n++; end
    checks++; if (bus1.done !== 1'b1 || bus1.index !== 4'd0 || bus1.busy !== 1'b0)
      $display("FAIL single_done got done=%b idx=%0d busy=%b want 1 0 0", bus1.done, bus1.index, bus1.busy); else passes++;
    repeat (20) @(negedge clk);
    checks++; if (bus1.enable !== 1'b0 || bus1.done !== 1'b1)
      $display("FAIL single_hold got en=%b done=%b want 0 1", bus1.enable, bus1.done); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    fin_en = 1'b0;
    bus.start = 1'b0;
    bus1.start = 1'b0;
    bus1.finished = 1'b0;
    test_reset();
    test_full_run();
    test_timeout();
    test_start_filter();
    test_async_reset();
    test_single_word();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
